// File: rtl/la_pkg.sv
// Shared types and helpers for the logic-analyser capture engine.
package la_pkg;

  // FSM states; the encoding is visible on state_o, so keep it fixed.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4,
    ST_READ = 3'd5
  } la_state_e;

  // Widest trigger bus the compare helper accepts; narrower buses are zero-extended.
  localparam int LA_CMP_MAX_W = 64;

  // Address width for a buffer of 'depth' entries (at least one bit).
  function automatic int la_addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Masked compare; a cleared mask bit never blocks a hit.
  function automatic logic la_hit(input logic [LA_CMP_MAX_W-1:0] trig,
                                  input logic [LA_CMP_MAX_W-1:0] value,
                                  input logic [LA_CMP_MAX_W-1:0] mask);
    return ((trig ^ value) & mask) == '0;
  endfunction

  // Qualified event: plain level, or only on a false->true transition of the compare.
  function automatic logic la_event(input logic hit, input logic hit_q, input logic edge_mode);
    return edge_mode ? (hit & ~hit_q) : hit;
  endfunction

endpackage

// File: rtl/la_sample_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module la_sample_ram
  import la_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = la_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port with one cycle latency; output holds while re is low, which the
  // readout logic relies on as a free holding stage.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyser capture engine: circular sampling, masked/edge trigger with
// occurrence counter, pre/post windows, and oldest-first valid/ready readout.
module la_capture_core
  import la_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TRIG_W = 27,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = la_addr_w(DEPTH),
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [TRIG_W-1:0] trig_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TRIG_W-1:0] trig_mask_i,
  input  logic [TRIG_W-1:0] trig_value_i,
  input  logic              trig_edge_i,
  input  logic [CNT_W-1:0]  trig_count_i,
  input  logic [ADDR_W-1:0] pre_len_i,
  input  logic              rd_start_i,
  input  logic              rd_ready_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_last_o,
  output logic [2:0]        state_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] trig_pos_o
);

  la_state_e         state_q, state_d;

  // capture side
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] pre_cnt_q;
  logic [ADDR_W-1:0] pre_len_q;
  logic [ADDR_W-1:0] post_cnt_q;
  logic [ADDR_W-1:0] post_len;
  logic [ADDR_W-1:0] trig_pos_q;
  logic [CNT_W-1:0]  ev_cnt_q;
  logic [CNT_W-1:0]  need;
  logic [CNT_W:0]    ev_next;
  logic              hit, hit_q, evt;
  logic              wr_en, fire, start;
  logic              done_q;

  // readout side
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   iss_cnt_q;
  logic              ram_vld_q, ram_last_q;
  logic              out_vld_q, out_last_q;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] ram_q;
  logic              ren, mv;

  // pre_len_i is ADDR_W wide, so it can never exceed DEPTH-1; no further clamp needed.
  // It is latched at arm so the pre window, post length and readout start agree.
  assign post_len = ADDR_W'(DEPTH - 1) - pre_len_q;
  assign need     = (trig_count_i == '0) ? CNT_W'(1) : trig_count_i;
  assign ev_next  = {1'b0, ev_cnt_q} + (CNT_W+1)'(1);
  assign hit      = la_hit(LA_CMP_MAX_W'(trig_i), LA_CMP_MAX_W'(trig_value_i),
                           LA_CMP_MAX_W'(trig_mask_i));
  assign evt      = la_event(hit, hit_q, trig_edge_i);
  assign start    = (state_d == ST_PRE) && (state_q != ST_PRE);

  // Readout: the RAM output register is one stage, out_* is the second.
  // Move RAM->out whenever out is empty or draining; issue a read whenever the
  // RAM stage is empty or being vacated this cycle.
  assign mv  = ram_vld_q && (!out_vld_q || rd_ready_i);
  assign ren = (state_q == ST_READ) && !abort_i && !iss_cnt_q[ADDR_W] && (!ram_vld_q || mv);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state plus per-cycle write/trigger strobes; abort overrides everything.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    fire    = 1'b0;
    case (state_q)
      ST_IDLE: if (arm_i) state_d = ST_PRE;
      ST_PRE: begin
        wr_en = 1'b1;
        if (pre_cnt_q == pre_len_q) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wr_en = 1'b1;
        if (evt && (ev_next >= {1'b0, need})) begin
          fire    = 1'b1;
          state_d = (post_len == '0) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        wr_en = 1'b1;
        if (post_cnt_q == ADDR_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (arm_i)           state_d = ST_PRE;
        else if (rd_start_i) state_d = ST_READ;
      end
      ST_READ: if (out_vld_q && rd_ready_i && out_last_q) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_i) begin
      state_d = ST_IDLE;
      wr_en   = 1'b0;
      fire    = 1'b0;
    end
  end

  // Capture counters, trigger position and frozen flag.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q   <= '0;
      pre_cnt_q  <= '0;
      pre_len_q  <= '0;
      post_cnt_q <= '0;
      trig_pos_q <= '0;
      ev_cnt_q   <= '0;
      hit_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      hit_q  <= hit;
      done_q <= (state_d == ST_DONE) || (state_d == ST_READ);
      if (wr_en) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (state_q == ST_PRE) pre_cnt_q <= pre_cnt_q + ADDR_W'(1);
      if (state_q == ST_WAIT && evt && !abort_i) ev_cnt_q <= ev_next[CNT_W-1:0];
      if (state_q == ST_POST) post_cnt_q <= post_cnt_q - ADDR_W'(1);
      if (fire) begin
        trig_pos_q <= wr_ptr_q;
        post_cnt_q <= post_len;
      end
      if (start) begin
        wr_ptr_q  <= '0;
        pre_cnt_q <= '0;
        ev_cnt_q  <= '0;
        hit_q     <= 1'b0;
        pre_len_q <= pre_len_i;
      end
    end
  end

  // Readout address/issue tracking and the two-stage valid/ready pipeline.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rd_ptr_q   <= '0;
      iss_cnt_q  <= '0;
      ram_vld_q  <= 1'b0;
      ram_last_q <= 1'b0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      if (state_q == ST_DONE && state_d == ST_READ) begin
        rd_ptr_q  <= trig_pos_q - pre_len_q;
        iss_cnt_q <= '0;
      end
      if (ren) begin
        rd_ptr_q   <= rd_ptr_q + ADDR_W'(1);
        iss_cnt_q  <= iss_cnt_q + (ADDR_W+1)'(1);
        ram_last_q <= (iss_cnt_q == (ADDR_W+1)'(DEPTH - 1));
      end
      if (state_d != ST_READ) begin
        ram_vld_q <= 1'b0;
        out_vld_q <= 1'b0;
      end else begin
        ram_vld_q <= ren || (ram_vld_q && !mv);
        if (mv) begin
          out_vld_q  <= 1'b1;
          out_data_q <= ram_q;
          out_last_q <= ram_last_q;
        end else if (out_vld_q && rd_ready_i) begin
          out_vld_q <= 1'b0;
        end
      end
    end
  end

  la_sample_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk_i),
    .we   (wr_en),
    .waddr(wr_ptr_q),
    .wdata(data_i),
    .re   (ren),
    .raddr(rd_ptr_q),
    .rdata(ram_q)
  );

  assign rd_valid_o = out_vld_q;
  assign rd_data_o  = out_data_q;
  assign rd_last_o  = out_vld_q & out_last_q;
  assign state_o    = state_q;
  assign done_o     = done_q;
  assign trig_pos_o = trig_pos_q;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed + randomized bench for la_capture_core with a sample-history reference model.
module tb_la_capture_core;

  localparam int DW = 32, TW = 27, D = 16, AW = 4, CW = 8, NS = 512;

  logic          clk = 1'b0;
  logic          rstn, arm, abort, trig_edge, rd_start, rd_ready;
  logic [TW-1:0] trig, trig_mask, trig_value;
  logic [DW-1:0] data;
  logic [CW-1:0] trig_count;
  logic [AW-1:0] pre_len;
  logic          rd_valid, rd_last, done;
  logic [DW-1:0] rd_data;
  logic [2:0]    state;
  logic [AW-1:0] trig_pos;

  int n_asrt = 0, n_fail = 0;

  // configuration and pre-generated stimulus for one capture
  int            cfg_pre, cfg_count, exp_t;
  bit            cfg_edge;
  logic [TW-1:0] cfg_mask, cfg_value;
  logic [DW-1:0] s_data [NS];
  logic [TW-1:0] s_trig [NS];

  la_capture_core #(.DATA_W(DW), .TRIG_W(TW), .DEPTH(D), .CNT_W(CW)) dut (
    .clk_i(clk), .rstn_i(rstn), .arm_i(arm), .abort_i(abort),
    .trig_i(trig), .data_i(data), .trig_mask_i(trig_mask), .trig_value_i(trig_value),
    .trig_edge_i(trig_edge), .trig_count_i(trig_count), .pre_len_i(pre_len),
    .rd_start_i(rd_start), .rd_ready_i(rd_ready), .rd_valid_o(rd_valid),
    .rd_data_o(rd_data), .rd_last_o(rd_last), .state_o(state), .done_o(done),
    .trig_pos_o(trig_pos)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: sample j is the j-th sample written after arm. Samples 0..pre
  // form the pre window (events ignored); the trigger is the need-th event after it.
  function automatic int find_trigger();
    int ev, need;
    bit hp, h, e;
    need = (cfg_count == 0) ? 1 : cfg_count;
    ev = 0; hp = 1'b0;
    for (int j = 0; j < NS - D; j++) begin
      h = (((s_trig[j] ^ cfg_value) & cfg_mask) == '0);
      if (j > cfg_pre) begin
        e = cfg_edge ? (h && !hp) : h;
        if (e) begin
          ev++;
          if (ev == need) return j;
        end
      end
      hp = h;
    end
    return -1;
  endfunction

  task automatic apply_cfg();
    trig_mask  = cfg_mask;
    trig_value = cfg_value;
    trig_edge  = cfg_edge;
    trig_count = CW'(cfg_count);
    pre_len    = AW'(cfg_pre);
    exp_t      = find_trigger();
  endtask

  task automatic gen_random(input int nbits, input int pre);
    int tries = 0;
    do begin
      cfg_pre   = (pre < 0) ? int'($urandom_range(D - 1)) : pre;
      cfg_count = $urandom_range(3);
      cfg_edge  = bit'($urandom_range(1));
      cfg_mask  = '0;
      repeat (nbits) cfg_mask[$urandom_range(TW - 1)] = 1'b1;
      cfg_value = TW'($urandom);
      for (int j = 0; j < NS; j++) begin
        s_data[j] = $urandom;
        s_trig[j] = TW'($urandom);
      end
      if (tries > 40) cfg_mask = '0;
      apply_cfg();
      tries++;
    end while (exp_t < 0);
  endtask

  // Arm, stream the pre-generated samples, check window transitions and DONE.
  task automatic capture(input int abort_at, input int arm_at, input int rst_at);
    int n;
    n = exp_t + D - cfg_pre;
    @(negedge clk);
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    for (int j = 0; j < n; j++) begin
      data  = s_data[j];
      trig  = s_trig[j];
      abort = (j == abort_at);
      arm   = (j == arm_at);
      rstn  = !(j == rst_at);
      @(posedge clk); #1;
      abort = 1'b0; arm = 1'b0; rstn = 1'b1;
      if (j == abort_at || j == rst_at) begin
        chk("cut_state", state, 0);
        chk("cut_done", done, 0);
        chk("cut_valid", rd_valid, 0);
        if (j == rst_at) chk("rst_trig_pos", trig_pos, 0);
        return;
      end
      if (j == cfg_pre) chk("wait_entry", state, 2);
      if (j == exp_t) begin
        chk("trig_pos", trig_pos, exp_t % D);
        chk("post_entry", state, (cfg_pre == D - 1) ? 4 : 3);
      end
      if (j == n - 2) chk("done_early", done, 0);
    end
    chk("done_set", done, 1);
    chk("done_state", state, 4);
    // writes must be frozen now: keep the bus moving
    repeat (3) begin
      data = $urandom; trig = TW'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // Read the capture, optionally aborting after abort_k handshakes.
  task automatic readout(input int rdy_pct, input int abort_k);
    int k, cyc, base;
    logic [DW-1:0] held;
    bit stalled;
    k = 0; cyc = 0; stalled = 1'b0; held = '0;
    base = exp_t - cfg_pre;
    @(negedge clk);
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    chk("rd_enter", state, 5);
    while (k < D && cyc < 300) begin
      if (k == abort_k) begin
        abort = 1'b1; rd_ready = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("rd_abort_state", state, 0);
        chk("rd_abort_valid", rd_valid, 0);
        return;
      end
      rd_ready = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      if (stalled) begin
        chk("rd_stall_valid", rd_valid, 1);
        chk("rd_stall_data", rd_data, held);
      end
      if (rd_valid) begin
        if (rd_ready) begin
          chk("rd_data", rd_data, s_data[base + k]);
          chk("rd_last", rd_last, (k == D - 1));
          k++;
          stalled = 1'b0;
        end else begin
          held = rd_data;
          stalled = 1'b1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    rd_ready = 1'b0;
    chk("rd_count", k, D);
    chk("rd_back_done", state, 4);
    chk("rd_valid_off", rd_valid, 0);
  endtask

  task automatic setup_counter();
    cfg_pre = 4; cfg_count = 1; cfg_edge = 1'b0;
    cfg_mask = '1; cfg_value = TW'(9);
    for (int j = 0; j < NS; j++) begin
      s_data[j] = DW'(j);
      s_trig[j] = TW'(j);
    end
    apply_cfg();
  endtask

  initial begin
    rstn = 1'b0; arm = 1'b0; abort = 1'b0; rd_start = 1'b0; rd_ready = 1'b0;
    trig = '0; data = '0; trig_mask = '0; trig_value = '0; trig_edge = 1'b0;
    trig_count = '0; pre_len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_done", done, 0);
    chk("rst_trig_pos", trig_pos, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_last", rd_last, 0);
    chk("rst_data", rd_data, 0);
    rstn = 1'b1;

    // counter data, level trigger on value 9
    setup_counter();
    capture(-1, -1, -1);
    readout(100, -1);

    // edge mode, 3rd rising edge of bit0 toggling every 2 samples
    cfg_pre = 4; cfg_count = 3; cfg_edge = 1'b1;
    cfg_mask = TW'(1); cfg_value = TW'(1);
    for (int j = 0; j < NS; j++) begin
      s_data[j] = DW'(j);
      s_trig[j] = TW'((j >> 1) & 1);
    end
    apply_cfg();
    capture(-1, -1, -1);
    readout(100, -1);

    // level mode, steady match: fires on the first qualified sample
    cfg_pre = 4; cfg_count = 1; cfg_edge = 1'b0;
    cfg_mask = TW'(1); cfg_value = TW'(1);
    for (int j = 0; j < NS; j++) begin
      s_data[j] = $urandom;
      s_trig[j] = TW'(1);
    end
    apply_cfg();
    capture(-1, -1, -1);
    readout(100, -1);

    // window extremes with stalled readout
    gen_random(3, 0);
    capture(-1, -1, -1);
    readout(30, -1);
    gen_random(3, D - 1);
    capture(-1, -1, -1);
    readout(30, -1);

    // abort in WAIT, abort in POST, ignored arm in POST
    setup_counter();
    capture(7, -1, -1);
    capture(12, -1, -1);
    capture(-1, 12, -1);
    readout(100, -1);

    // reset in POST, clean re-arm, re-read twice, then abort mid-readout
    capture(-1, -1, 13);
    gen_random(4, -1);
    capture(-1, -1, -1);
    readout(30, -1);
    readout(60, -1);
    readout(100, 5);

    // randomized captures with long waits (buffer wraps many times)
    for (int it = 0; it < 6; it++) begin
      gen_random(4 + (it % 2), -1);
      capture(-1, -1, -1);
      readout(30, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
